// File: rtl/uart_tx_stim_if.sv
// Byte-enqueue handshake for the UART stimulus transmitter.
// The master offers bytes; the slave (transmitter FIFO) reports whether it can accept them.
`timescale 1ns/1ps
interface uart_tx_stim_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_stim.sv
// 8N1 UART transmitter with a byte FIFO, used to inject console input into the SoC receive line.
// The baud divisor is latched per frame, so frames are never retimed mid-flight.
`timescale 1ns/1ps
module uart_tx_stim #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DIV_W-1:0]            baud_div_i,
    uart_tx_stim_if.slave               tx,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
    output logic                        busy_o,
    output logic                        frame_done_o,
    output logic                        txd_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FullCnt = FIFO_DEPTH[AW:0];

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e           state_q;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic [DIV_W-1:0] div_q, bcnt_q, div_new;
    logic [2:0]       idx_q;
    logic [7:0]       shift_q;
    logic             txd_q, frame_done_q;
    logic             full, push, pop, bit_end;

    assign full        = (count_q == FullCnt);
    assign tx.tx_ready = !full;
    assign push        = tx.tx_valid && !full;
    assign bit_end     = (bcnt_q == div_q - DIV_W'(1));
    assign div_new     = (baud_div_i == '0) ? DIV_W'(1) : baud_div_i;
    // A byte leaves the FIFO either from idle or exactly at the end of a stop bit.
    assign pop = (count_q != '0) &&
                 ((state_q == StIdle) || ((state_q == StStop) && bit_end));

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= tx.tx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            bcnt_q       <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            div_q        <= DIV_W'(1);
            txd_q        <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pop) begin
                        shift_q <= mem_q[rd_ptr_q];
                        div_q   <= div_new;
                        bcnt_q  <= '0;
                        txd_q   <= 1'b0;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        bcnt_q  <= '0;
                        idx_q   <= '0;
                        txd_q   <= shift_q[0];
                        state_q <= StData;
                    end else begin
                        bcnt_q <= bcnt_q + DIV_W'(1);
                    end
                end
                StData: begin
                    if (bit_end) begin
                        bcnt_q <= '0;
                        if (idx_q == 3'd7) begin
                            txd_q        <= 1'b1;
                            state_q      <= StStop;
                            // A one-cycle stop bit is its own final cycle.
                            frame_done_q <= (div_q == DIV_W'(1));
                        end else begin
                            shift_q <= shift_q >> 1;
                            idx_q   <= idx_q + 3'd1;
                            txd_q   <= shift_q[1];
                        end
                    end else begin
                        bcnt_q <= bcnt_q + DIV_W'(1);
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        bcnt_q <= '0;
                        if (pop) begin
                            shift_q <= mem_q[rd_ptr_q];
                            div_q   <= div_new;
                            txd_q   <= 1'b0;
                            state_q <= StStart;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        bcnt_q       <= bcnt_q + DIV_W'(1);
                        frame_done_q <= ((bcnt_q + DIV_W'(1)) == (div_q - DIV_W'(1)));
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign fifo_count_o = count_q;
    assign busy_o       = (state_q != StIdle);
    assign frame_done_o = frame_done_q;
    assign txd_o        = txd_q;

endmodule

// File: tb/tb_uart_tx_stim.sv
// Scoreboard bench for uart_tx_stim: pushes queue expected (byte, divisor) pairs and a
// line monitor decodes every frame cycle by cycle against them.
`timescale 1ns/1ps
module tb_uart_tx_stim;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned DW    = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] baud_div;
    logic [4:0]    fifo_count;
    logic          busy, frame_done, txd;

    uart_tx_stim_if u_if ();

    uart_tx_stim #(.FIFO_DEPTH(DEPTH), .DIV_W(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .baud_div_i   (baud_div),
        .tx           (u_if),
        .fifo_count_o (fifo_count),
        .busy_o       (busy),
        .frame_done_o (frame_done),
        .txd_o        (txd)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         pulses = 0;
    int         idle_viol = 0;
    logic [7:0] exp_data[$];
    int         exp_div[$];
    int         starts[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && !busy && !txd) idle_viol <= idle_viol + 1;
        if (frame_done) pulses <= pulses + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Follows one frame from its first start-bit cycle to its last stop-bit cycle.
    task automatic run_frame();
        logic [7:0] e_byte;
        logic [7:0] rx;
        logic       exp_bit;
        int         d, b;
        int         bad_wave = 0;
        int         bad_done = 0;
        starts.push_back(cyc);
        if (exp_data.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_frame: got start bit, expected idle line (cycle %0d)", cyc);
            for (int i = 0; i < 5000 && busy; i++) @(negedge clk);
            return;
        end
        e_byte = exp_data.pop_front();
        d      = exp_div.pop_front();
        rx     = '0;
        for (int t = 0; t < 10 * d; t++) begin
            if (t > 0) @(negedge clk);
            if (!rst_n) return;
            b = t / d;
            exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : e_byte[b-1];
            if (txd !== exp_bit) bad_wave++;
            if (frame_done !== (t == 10 * d - 1)) bad_done++;
            if (b >= 1 && b <= 8 && (t % d) == d / 2) rx[b-1] = txd;
        end
        check("frame_data", rx, e_byte);
        check("frame_wave_bad_cycles", bad_wave, 0);
        check("frame_done_bad_cycles", bad_done, 0);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n && txd === 1'b0) run_frame();
        end
    end

    // Called at a negedge; leaves tx_valid high so consecutive calls push back to back.
    task automatic push_byte(input logic [7:0] b, input int d, output int waited);
        waited = 0;
        u_if.tx_data  = b;
        u_if.tx_valid = 1'b1;
        while (!u_if.tx_ready && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        if (!u_if.tx_ready) begin
            tests++;
            fails++;
            $display("FAIL push_timeout: got tx_ready=0, expected 1 (byte 0x%0h)", b);
            u_if.tx_valid = 1'b0;
            return;
        end
        exp_data.push_back(b);
        exp_div.push_back(d);
        @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int w = 0;
        while ((busy || fifo_count != 0 || exp_data.size() != 0) && w < budget) begin
            @(negedge clk);
            w++;
        end
        check("drain_pending", (busy || fifo_count != 0 || exp_data.size() != 0), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int w, s0, p0, gap;
        logic [7:0] rb;
        u_if.tx_data  = '0;
        u_if.tx_valid = 1'b0;
        baud_div      = DW'(4);
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_txd", txd, 1);
        check("rst_ready", u_if.tx_ready, 1);
        check("rst_count", fifo_count, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: div=4, 0x55, exact edge timing
        u_if.tx_data  = 8'h55;
        u_if.tx_valid = 1'b1;
        exp_data.push_back(8'h55);
        exp_div.push_back(4);
        @(negedge clk);
        u_if.tx_valid = 1'b0;
        check("t1_txd_e0", txd, 1);
        check("t1_count_e0", fifo_count, 1);
        check("t1_busy_e0", busy, 0);
        @(negedge clk);
        check("t1_txd_e1", txd, 0);
        check("t1_busy_e1", busy, 1);
        check("t1_count_e1", fifo_count, 0);
        repeat (39) @(negedge clk);
        check("t1_done_e40", frame_done, 1);
        check("t1_busy_e40", busy, 1);
        @(negedge clk);
        check("t1_busy_e41", busy, 0);
        check("t1_done_e41", frame_done, 0);
        check("t1_txd_e41", txd, 1);

        // Test 2: div=1 back-to-back frames
        baud_div = DW'(1);
        s0 = starts.size();
        p0 = pulses;
        push_byte(8'hA5, 1, w);
        push_byte(8'h3C, 1, w);
        u_if.tx_valid = 1'b0;
        wait_drain(200);
        check("t2_frames", starts.size() - s0, 2);
        if (starts.size() >= s0 + 2) check("t2_gap", starts[s0+1] - starts[s0], 10);
        check("t2_done_pulses", pulses - p0, 2);

        // Test 3: fill the FIFO at div=8
        baud_div = DW'(8);
        for (int i = 0; i <= 16; i++) push_byte(8'(i), 8, w);
        check("t3_count_full", fifo_count, 16);
        check("t3_ready_full", u_if.tx_ready, 0);
        push_byte(8'h11, 8, w);
        check("t3_stalled", (w > 0), 1);
        check("t3_count_refill", fifo_count, 16);
        u_if.tx_valid = 1'b0;
        wait_drain(2000);

        // Test 4: reset in the middle of a 0xFF frame with 3 bytes queued
        push_byte(8'hFF, 8, w);
        push_byte(8'h01, 8, w);
        push_byte(8'h02, 8, w);
        push_byte(8'h03, 8, w);
        u_if.tx_valid = 1'b0;
        repeat (30) @(negedge clk);
        check("t4_busy_pre", busy, 1);
        check("t4_count_pre", fifo_count, 3);
        #2 rst_n = 1'b0;
        #1;
        check("t4_txd", txd, 1);
        check("t4_count", fifo_count, 0);
        check("t4_busy", busy, 0);
        check("t4_ready", u_if.tx_ready, 1);
        exp_data.delete();
        exp_div.delete();
        s0 = starts.size();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check("t4_no_tx_frames", starts.size() - s0, 0);
        check("t4_busy_after", busy, 0);
        check("t4_txd_after", txd, 1);

        // Test 5: div=0 acts as 1; divisor change mid-frame applies to the next frame
        baud_div = '0;
        s0 = starts.size();
        push_byte(8'h81, 1, w);
        push_byte(8'h42, 6, w);
        u_if.tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        baud_div = DW'(6);
        wait_drain(300);
        check("t5_frames", starts.size() - s0, 2);
        if (starts.size() >= s0 + 2) check("t5_first_len", starts[s0+1] - starts[s0], 10);

        // Test 6: 64 random bytes at div=16 with random valid gaps
        baud_div = DW'(16);
        for (int i = 0; i < 64; i++) begin
            rb  = 8'($urandom);
            gap = $urandom_range(0, 3);
            push_byte(rb, 16, w);
            u_if.tx_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        wait_drain(12000);
        check("idle_low_violations", idle_viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
